// File: rtl/vlsu_meta_buffer.sv
// Circular FIFO holding per-fragment {global, segment-level} metadata between the
// VLSU control machine and the load/store data controller.
module vlsu_meta_buffer #(
    parameter int unsigned Depth        = 4,
    parameter type         meta_glb_t   = logic,
    parameter type         meta_seglv_t = logic,
    localparam int unsigned CntW        = $clog2(Depth + 1),
    localparam int unsigned PtrW        = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enq_valid_i,
    output logic              enq_ready_o,
    input  meta_glb_t         enq_glb_i,
    input  meta_seglv_t       enq_seglv_i,
    output logic              deq_valid_o,
    input  logic              deq_ready_i,
    output meta_glb_t         deq_glb_o,
    output meta_seglv_t       deq_seglv_o,
    input  logic              flush_i,
    output logic [CntW-1:0]   count_o,
    output logic              empty_o,
    output logic              full_o
);

    meta_glb_t   glb_q   [Depth];
    meta_seglv_t seglv_q [Depth];

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enq_fire;
    logic            deq_fire;

    // Ready/valid derive only from registered occupancy, so a full buffer never
    // opens a combinational path from the data controller back to the control machine.
    assign enq_ready_o = (cnt_q != CntW'(Depth));
    assign deq_valid_o = (cnt_q != '0);
    assign deq_glb_o   = glb_q[rptr_q];
    assign deq_seglv_o = seglv_q[rptr_q];
    assign count_o     = cnt_q;
    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CntW'(Depth));

    assign enq_fire = enq_valid_i && enq_ready_o;
    assign deq_fire = deq_valid_o && deq_ready_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq_fire) wptr_d = wptr_q + PtrW'(1);
            if (deq_fire) rptr_d = rptr_q + PtrW'(1);
            unique case ({enq_fire, deq_fire})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is intentionally unreset; entries are only observed while counted valid.
    always_ff @(posedge clk_i) begin
        if (enq_fire && !flush_i) begin
            glb_q[wptr_q]   <= enq_glb_i;
            seglv_q[wptr_q] <= enq_seglv_i;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntW'(Depth));

    a_no_enq_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        full_o |-> !enq_fire);

    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        empty_o |-> !deq_fire);

    a_deq_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (deq_valid_o && !deq_ready_i && !flush_i) |=>
            (deq_valid_o && $stable(deq_glb_o) && $stable(deq_seglv_o)));

    a_enq_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (enq_valid_i && !enq_ready_o && !flush_i) |=>
            (!enq_valid_i || ($stable(enq_glb_i) && $stable(enq_seglv_i))));

endmodule

// File: tb/tb_vlsu_meta_buffer.sv
// Bench for vlsu_meta_buffer: directed vector table, hand sequences and a
// randomized run checked against a queue-based reference model.
module tb_vlsu_meta_buffer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       enq_valid;
    logic       enq_ready;
    logic [7:0] enq_glb;
    logic [7:0] enq_seglv;
    logic       deq_valid;
    logic       deq_ready;
    logic [7:0] deq_glb;
    logic [7:0] deq_seglv;
    logic       flush;
    logic [2:0] count;
    logic       empty;
    logic       full;

    vlsu_meta_buffer #(
        .Depth        (DEPTH),
        .meta_glb_t   (logic [7:0]),
        .meta_seglv_t (logic [7:0])
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enq_valid_i (enq_valid),
        .enq_ready_o (enq_ready),
        .enq_glb_i   (enq_glb),
        .enq_seglv_i (enq_seglv),
        .deq_valid_o (deq_valid),
        .deq_ready_i (deq_ready),
        .deq_glb_o   (deq_glb),
        .deq_seglv_o (deq_seglv),
        .flush_i     (flush),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model: the buffer contents as a plain queue of {glb, seglv}.
    logic [15:0] mq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
        chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
        chk({tag, ".enq_ready"}, int'(enq_ready), int'(mq.size() < DEPTH));
        chk({tag, ".deq_valid"}, int'(deq_valid), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk({tag, ".deq_seglv"}, int'(deq_seglv), int'(mq[0][7:0]));
            chk({tag, ".deq_glb"}, int'(deq_glb), int'(mq[0][15:8]));
        end
    endtask

    // Called at a negedge: drive inputs, advance the model across the next
    // posedge, then land on the following negedge with outputs settled.
    task automatic cycle(input logic ev, input logic [7:0] sv, input logic dr, input logic fl);
        int sz;
        enq_valid = ev;
        enq_seglv = sv;
        enq_glb   = sv ^ 8'hA5;
        deq_ready = dr;
        flush     = fl;
        sz = mq.size();
        if (fl) mq.delete();
        else begin
            if (dr && sz > 0) void'(mq.pop_front());
            if (ev && sz < DEPTH) mq.push_back({sv ^ 8'hA5, sv});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       ev;
        logic [7:0] sv;
        logic       dr;
        logic       fl;
        int         exp_cnt;
        logic       exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic       hold;
        logic [7:0] hold_sv;
        logic       ev, dr, fl;
        logic [7:0] sv;
        int         sz;

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        enq_valid = 1'b0;
        enq_glb = '0;
        enq_seglv = '0;
        deq_ready = 1'b0;
        flush = 1'b0;

        //          ev   sv     dr   fl   cnt rdy  vld  head
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h01};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b1, 1'b1, 8'h01};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b1, 1'b1, 8'h01};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'h01};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'h02};
        vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'h02};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'h03};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'h04};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h05};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 8'h31, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h31};
        vecs[12] = '{1'b1, 8'h32, 1'b0, 1'b0, 2, 1'b1, 1'b1, 8'h31};
        vecs[13] = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b1, 1'b1, 8'h31};
        vecs[14] = '{1'b1, 8'h34, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[15] = '{1'b1, 8'h07, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h07};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        vecs[17] = '{1'b1, 8'h08, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h08};
        vecs[18] = '{1'b1, 8'h09, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h09};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("in_reset.enq_ready", int'(enq_ready), 1);
        chk("in_reset.deq_valid", int'(deq_valid), 0);
        chk("in_reset.count", int'(count), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            model_check("idle");
        end

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].ev, vecs[i].sv, vecs[i].dr, vecs[i].fl);
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_cnt);
            chk($sformatf("vec%0d.enq_ready", i), int'(enq_ready), int'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d.deq_valid", i), int'(deq_valid), int'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("vec%0d.head", i), int'(deq_seglv), int'(vecs[i].exp_head));
                chk($sformatf("vec%0d.head_glb", i), int'(deq_glb), int'(vecs[i].exp_head ^ 8'hA5));
            end
        end

        // Steady stream 0x10..0x23 with consumer always ready
        for (int i = 0; i < 20; i++) begin
            if (deq_valid) chk("stream.order", int'(deq_seglv), 8'h10 + i - 1);
            cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            chk("stream.count", int'(count), 1);
        end
        chk("stream.last", int'(deq_seglv), 8'h23);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        model_check("stream_end");

        // Randomized traffic; a refused enqueue is held until accepted or flushed
        hold = 1'b0;
        hold_sv = '0;
        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 49) == 0);
            dr = ($urandom_range(0, 99) < 45);
            if (hold) begin
                ev = 1'b1;
                sv = hold_sv;
            end else begin
                ev = ($urandom_range(0, 99) < 60);
                sv = 8'($urandom);
            end
            sz = mq.size();
            hold = ev && (sz == DEPTH) && !fl;
            hold_sv = sv;
            cycle(ev, sv, dr, fl);
            model_check("rand");
        end

        // Asynchronous reset with two entries held
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        model_check("pre_areset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.count", int'(count), 0);
        chk("areset.enq_ready", int'(enq_ready), 1);
        chk("areset.deq_valid", int'(deq_valid), 0);
        chk("areset.empty", int'(empty), 1);
        chk("areset.full", int'(full), 0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        model_check("post_areset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vlsu_meta_buffer.md
Name: vlsu_meta_buffer

Overview:
Meta buffer directly downstream of the VLSU control machine. It accepts per-fragment metadata (global plus segment-level) over a valid/ready handshake and stores it in order in a circular FIFO. It then presents the metadata to the load/store data controller, which consumes one entry per fragment it finishes. Its ready output is the control machine's meta_ctrl_ready_i input, so buffer full directly back-pressures request fragmentation.

Parameters:
Depth, 4, number of entries; power of two, >= 2
meta_glb_t, logic, global (per-request) metadata type
meta_seglv_t, logic, segment-level (per-fragment) metadata type
CntW (derived), $clog2(Depth+1), occupancy counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enq_valid_i  in  1  metadata valid from control machine (meta_ctrl_valid_o)
enq_ready_o  out  1  buffer can accept; drives control machine meta_ctrl_ready_i
enq_glb_i  in  $bits(meta_glb_t)  global metadata
enq_seglv_i  in  $bits(meta_seglv_t)  segment-level metadata
deq_valid_o  out  1  head entry valid toward data controller
deq_ready_i  in  1  data controller consumes head entry
deq_glb_o  out  $bits(meta_glb_t)  head global metadata
deq_seglv_o  out  $bits(meta_seglv_t)  head segment-level metadata
flush_i  in  1  synchronous discard of all entries (abort/exception)
count_o  out  CntW  current occupancy
empty_o  out  1  occupancy == 0
full_o  out  1  occupancy == Depth

Behaviour:
- Storage: Depth-entry circular array of {glb, seglv}; write pointer wptr, read pointer rptr, each $clog2(Depth) bits.
- Occupancy counter cnt is 0..Depth; pointers wrap modulo Depth by natural overflow.
- Reset (async, rst_ni=0): wptr=rptr=0, cnt=0.
  - Output values during reset: enq_ready_o=1, deq_valid_o=0, count_o=0, empty_o=1, full_o=0.
  - Storage array is not reset; deq_glb_o/deq_seglv_o are don't-care while deq_valid_o=0.
- enq_ready_o = (cnt != Depth). This is purely a function of registered state; there is no combinational path from deq_ready_i.
- Enqueue fire: enq_valid_i && enq_ready_o.
  - Writes entry[wptr] and increments wptr at the clock edge.
- deq_valid_o = (cnt != 0). deq_glb_o/deq_seglv_o = entry[rptr], read combinationally from registered storage.
- Dequeue fire: deq_valid_o && deq_ready_i. Increments rptr.
- Latency: an entry enqueued at edge N is visible at deq_* after edge N, i.e. 1 cycle. There is no same-cycle fall-through when empty.
- cnt update per cycle:
  - +1 on enqueue fire only.
  - -1 on dequeue fire only.
  - Unchanged when both fire or neither fires.
- Full with dequeue in the same cycle: enq_ready_o stays 0 (no bypass). The freed slot becomes available next cycle.
- Empty with enqueue in the same cycle: no dequeue can fire. The entry appears the next cycle.
- Simultaneous enqueue and dequeue at 0 < cnt < Depth: both pointers advance and cnt is held.
- Order: strict FIFO. Entries are never reordered, dropped or duplicated.
- flush_i = 1 at an edge: wptr=rptr=0, cnt=0.
  - Enqueue and dequeue fires in the same cycle are ignored; flush has priority.
  - deq_valid_o=0 from the next cycle.
- Handshake obligations:
  - Once asserted, deq_valid_o stays high with stable data until a dequeue fire or flush.
  - The upstream side must hold enq_* stable while enq_valid_i && !enq_ready_o. The buffer does not check this; assert it in simulation.
- Assertions:
  - cnt <= Depth.
  - No enqueue fire when full.
  - No dequeue fire when empty.
  - deq_* stable while deq_valid_o && !deq_ready_i.

Test Plan:
- Reset then idle -> enq_ready_o=1, deq_valid_o=0, count_o=0, empty_o=1 throughout.
- Depth=4: enqueue seglv 0x1,0x2,0x3,0x4 back-to-back with deq_ready_i=0 -> count_o=4, full_o=1, enq_ready_o=0. A fifth presented 0x5 is not accepted and count_o stays 4.
- From full, deq_ready_i=1 for 4 cycles -> outputs 0x1,0x2,0x3,0x4 in order. enq_ready_o=1 one cycle after the first dequeue. Ends with empty_o=1.
- Steady stream: enq_valid_i=1 and deq_ready_i=1 every cycle for 20 entries (0x10..0x23) -> count_o settles at 1, pointers wrap 5 times, and all 20 values are received in order.
- Full plus simultaneous deq fire with enq_valid_i=1 -> enqueue is not accepted that cycle. It is accepted the next cycle, and count_o goes 4,3,4.
- 3 entries stored, flush_i=1 alongside an enq fire -> next cycle count_o=0, deq_valid_o=0. A subsequent enqueue of 0x7 appears at the head after 1 cycle.
- Assert rst_ni=0 mid-stream with count_o=2 -> all outputs return to reset values immediately, without waiting for a clock edge.
